// File: rtl/secded_decoder_seq_if.sv
// Codeword bus between a SECDED decoder and its source/sink.
interface secded_decoder_seq_if;
  logic [71:0] data_in;
  logic [71:0] data_out;
  logic        error_detected;
  logic        single_error;
  logic        double_error;

  modport master (output data_in,
                  input  data_out, error_detected, single_error, double_error);
  modport slave  (input  data_in,
                  output data_out, error_detected, single_error, double_error);
endinterface

// File: rtl/secded_decoder_seq.sv
// 72/64 SECDED: shared position tables, 1-cycle encoder, 1-cycle decoder.
// Data bit i sits at Hamming position p(i); position 2^j is check bit 64+j.
package secded_pkg;
  // Hamming position of data bit idx: the (idx+1)-th non-power-of-two in 3..71
  function automatic logic [6:0] data_pos(input int idx);
    int         cnt;
    logic [6:0] r;
    cnt = 0;
    r   = '0;
    for (int p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) r = 7'(p);
        cnt++;
      end
    end
    return r;
  endfunction

  function automatic logic [447:0] build_pos();
    logic [447:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r = r | (448'(data_pos(i)) << (7 * i));
    return r;
  endfunction

  // Row j selects the data bits whose position has bit j set
  function automatic logic [447:0] build_masks();
    logic [447:0] m;
    m = '0;
    for (int j = 0; j < 7; j++)
      for (int i = 0; i < 64; i++)
        if (((data_pos(i) >> j) & 7'd1) != 7'd0) m = m | (448'd1 << (64 * j + i));
    return m;
  endfunction

  localparam logic [63:0][6:0] DATA_POS   = build_pos();
  localparam logic [6:0][63:0] CHECK_MASK = build_masks();
endpackage

module secded_encoder_seq
  import secded_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_in,
  output logic [71:0] data_out
);
  logic [6:0]  chk;
  logic [71:0] cw;

  for (genvar j = 0; j < 7; j++) begin : g_chk
    assign chk[j] = ^(data_in & CHECK_MASK[j]);
  end

  assign cw = {^{chk, data_in}, chk, data_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out <= '0;
    else        data_out <= cw;
  end
endmodule

module secded_decoder_seq
  import secded_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  secded_decoder_seq_if.slave  bus
);
  logic [6:0]  syn;
  logic        par;
  logic [71:0] flip;
  logic        single_c;
  logic        double_c;

  for (genvar j = 0; j < 7; j++) begin : g_syn
    assign syn[j]       = ^(bus.data_in[63:0] & CHECK_MASK[j]) ^ bus.data_in[64+j];
    assign flip[64+j]   = par && (syn == (7'd1 << j));
  end

  for (genvar i = 0; i < 64; i++) begin : g_flip
    assign flip[i] = par && (syn == DATA_POS[i]);
  end

  assign par      = ^bus.data_in;
  assign flip[71] = par && (syn == 7'd0);

  // Every syndrome in 1..71 names exactly one position, so odd parity there is correctable
  assign single_c = par && (syn <= 7'd71);
  assign double_c = (!par && (syn != 7'd0)) || (par && (syn > 7'd71));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out       <= '0;
      bus.error_detected <= 1'b0;
      bus.single_error   <= 1'b0;
      bus.double_error   <= 1'b0;
    end else begin
      bus.data_out       <= bus.data_in ^ flip;
      bus.error_detected <= single_c | double_c;
      bus.single_error   <= single_c;
      bus.double_error   <= double_c;
    end
  end
endmodule

// File: tb/tb_secded_decoder_seq.sv
// Scoreboarded bench for the SECDED decoder plus an encoder->decoder chain.
module tb_secded_decoder_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] enc_in;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  secded_decoder_seq_if dif();
  secded_decoder_seq_if cif();

  secded_decoder_seq dut  (.clk(clk), .rst_n(rst_n), .bus(dif));
  secded_encoder_seq enc  (.clk(clk), .rst_n(rst_n), .data_in(enc_in), .data_out(cif.data_in));
  secded_decoder_seq dec2 (.clk(clk), .rst_n(rst_n), .bus(cif));

  typedef struct {
    logic [71:0] cw;
    logic        e, s, d;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder straight from the position definition
  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [6:0]  c;
    logic [71:0] cw;
    int          k;
    c = '0;
    k = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((d >> k) & 64'd1) != 64'd0) c = c ^ 7'(p);
        k++;
      end
    end
    cw = {1'b0, c, d};
    cw[71] = ^cw[70:0];
    return cw;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive(input logic [71:0] cw, input logic [71:0] exp_cw,
                       input logic e, input logic s, input logic d, input string tag);
    exp_t x;
    @(negedge clk);
    dif.data_in = cw;
    sbq.push_back('{cw: exp_cw, e: e, s: s, d: d, tag: tag});
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk(x.tag, {dif.data_out, dif.error_detected, dif.single_error, dif.double_error},
        {x.cw, x.e, x.s, x.d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] cw, bad, cwb;
    logic [63:0] d;
    int          b0, b1;

    rst_n       = 1'b0;
    dif.data_in = encode(64'hA5A5_0F0F_1234_5678) ^ 72'h3;
    enc_in      = 64'h0;
    #2;
    chk("reset_async", {dif.data_out, dif.error_detected, dif.single_error, dif.double_error}, '0);
    @(posedge clk); #1;
    chk("reset_hold", {dif.data_out, dif.error_detected, dif.single_error, dif.double_error}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    cw = encode(64'hDEADBEEF_CAFECAFE);
    drive(cw ^ (72'd1 << 5), cw, 1'b1, 1'b1, 1'b0, "data_bit5");
    drive(72'h80_0000000000000000, 72'h0, 1'b1, 1'b1, 1'b0, "parity_bit71");
    cw  = encode(64'h12345678_9ABCDEF0);
    bad = cw ^ 72'h3;
    drive(bad, bad, 1'b1, 1'b0, 1'b1, "double_d0_d1");

    for (int n = 0; n < 8; n++) begin
      cw = encode(rnd64());
      drive(cw, cw, 1'b0, 1'b0, 1'b0, "clean");
    end
    cw = encode(64'h0);
    drive(cw, cw, 1'b0, 1'b0, 1'b0, "clean_zero");
    cw = encode('1);
    drive(cw, cw, 1'b0, 1'b0, 1'b0, "clean_ones");

    for (int b = 0; b < 72; b++) begin
      cw = encode(rnd64());
      drive(cw ^ (72'd1 << b), cw, 1'b1, 1'b1, 1'b0, $sformatf("single_b%0d", b));
    end

    for (int n = 0; n < 20; n++) begin
      b0  = $urandom_range(0, 71);
      b1  = (b0 + $urandom_range(1, 71)) % 72;
      cw  = encode(rnd64());
      bad = cw ^ (72'd1 << b0) ^ (72'd1 << b1);
      drive(bad, bad, 1'b1, 1'b0, 1'b1, $sformatf("double_b%0d_b%0d", b0, b1));
    end

    // Positions 71^32^8 give syndrome 111 with odd parity: out of range
    cw  = encode(rnd64());
    bad = cw ^ (72'd1 << 63) ^ (72'd1 << 69) ^ (72'd1 << 67);
    drive(bad, bad, 1'b1, 1'b0, 1'b1, "syndrome_gt71");

    // Encoder -> decoder chain, 2-cycle end-to-end
    for (int n = 0; n < 2; n++) begin
      d = (n == 0) ? 64'hDEADBEEF_CAFECAFE : 64'h12345678_9ABCDEF0;
      @(negedge clk);
      enc_in = d;
      @(posedge clk); #1;
      chk("enc_codeword", {3'b0, cif.data_in}, {3'b0, encode(d)});
      @(posedge clk); #1;
      chk("chain_out", {11'b0, cif.data_out[63:0], cif.error_detected, cif.single_error,
                        cif.double_error}, {11'b0, d, 3'b000});
    end

    // Mid-stream reset drops the in-flight word
    cw  = encode(rnd64());
    cwb = encode(rnd64());
    drive(cw, cw, 1'b0, 1'b0, 1'b0, "pre_reset");
    @(negedge clk);
    dif.data_in = cwb ^ (72'd1 << 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", {dif.data_out, dif.error_detected, dif.single_error, dif.double_error}, '0);
    @(posedge clk); #1;
    chk("mid_reset_hold", {dif.data_out, dif.error_detected, dif.single_error, dif.double_error}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", {dif.data_out, dif.error_detected, dif.single_error, dif.double_error},
        {cwb, 3'b110});
    drive(cw, cw, 1'b0, 1'b0, 1'b0, "post_reset_clean");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/secded_decoder_seq.md
SECDED_DECODER_SEQ -- requirements
Module: secded_decoder_seq

Interface
REQ-001 The module SHALL have no parameters; data width 64, codeword width 72, fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  72  received codeword: [63:0] data, [70:64] Hamming check bits c[6:0], [71] overall parity.
REQ-005 data_out  output  72  registered corrected codeword, same layout as data_in.
REQ-006 error_detected  output  1  registered; high when any error is detected.
REQ-007 single_error  output  1  registered; high on a corrected single-bit error.
REQ-008 double_error  output  1  registered; high on an uncorrectable error.

Function
REQ-009 Position map: data bit i SHALL occupy Hamming position p(i), the (i+1)-th integer in 1..71 that is not a power of two (p(0)=3, p(1)=5, p(2)=6, p(3)=7, p(4)=9, ..., p(63)=71).
REQ-010 Check bit c[j], j=0..6, SHALL equal the XOR of all data bits i with bit j of p(i) set; Hamming position 2^j SHALL map to codeword bit 64+j.
REQ-011 Overall parity bit [71] SHALL equal the XOR of codeword bits [70:0], so a valid codeword has even parity over all 72 bits.
REQ-012 Syndrome s[6:0] SHALL be the recomputed c[6:0] from data_in[63:0] XOR data_in[70:64]; P SHALL be the XOR of all 72 data_in bits.
REQ-013 s=0, P=0: no error; data_out = data_in; all flags 0.
REQ-014 P=1, s=0: single error in bit 71; data_out = data_in with bit 71 inverted; single_error=1, error_detected=1, double_error=0.
REQ-015 P=1, s=2^j: single error in check bit 64+j; invert that bit; flags as REQ-014.
REQ-016 P=1, s equal to a data position p(i): invert data bit i; flags as REQ-014.
REQ-017 P=1, s>71: uncorrectable; data_out = data_in unchanged; double_error=1, error_detected=1, single_error=0.
REQ-018 s!=0, P=0: double error; data_out = data_in unchanged; double_error=1, error_detected=1, single_error=0.
REQ-019 single_error and double_error SHALL never be high together; error_detected SHALL equal single_error OR double_error.
REQ-020 Latency SHALL be exactly 1 clock: data_in sampled at rising edge N appears on all outputs after edge N and holds until edge N+1.
REQ-021 The block SHALL be fully pipelined, accepting a new codeword every cycle, with no handshake or stall.
REQ-022 The companion encoder secded_encoder_seq SHALL produce this codeword layout from 64-bit data with 1-cycle registered latency; encoder plus decoder end-to-end latency is 2 cycles.

Reset
REQ-023 While rst_n=0, data_out SHALL be 72'h0 and all flags 0, asserted asynchronously without waiting for clk.
REQ-024 After rst_n rises, the first rising edge SHALL capture data_in normally.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight codeword; no stale value SHALL appear after release.

Verification
REQ-026 Encoder plus decoder, data 64'hDEADBEEF_CAFECAFE then 64'h12345678_9ABCDEF0, each held 2 cycles -> two edges after each input change, data_out[63:0] equals that input and all flags are 0.
REQ-027 Valid codeword of 64'hDEADBEEF_CAFECAFE with data bit 5 inverted -> one cycle later data_out[63:0]=64'hDEADBEEF_CAFECAFE, single_error=1, error_detected=1, double_error=0.
REQ-028 Valid codeword of 64'h0 with bit 71 inverted (72'h80_0000000000000000) -> data_out=72'h0, single_error=1, error_detected=1.
REQ-029 Valid codeword of 64'h12345678_9ABCDEF0 with data bits 0 and 1 inverted -> data_out equals the corrupted input, double_error=1, error_detected=1, single_error=0.
REQ-030 Drive a valid codeword, assert rst_n=0 between clock edges -> outputs go to 0 immediately; after release and one edge, outputs track data_in again.
